// File: rtl/firstband_reconstructor.sv
// Decoder-side inverse of the first-band predictor. It adds each signed residual to the
// previous reconstructed sample, restarting at zero per block, and clamps to the sample range.
module firstband_reconstructor #(
  parameter int DATA_WIDTH     = 16,
  parameter int BLOCK_SIZE_LOG = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  residual_valid,
  output logic                  residual_ready,
  input  logic [DATA_WIDTH:0]   residual_data,
  output logic                  x_valid,
  input  logic                  x_ready,
  output logic [DATA_WIDTH-1:0] x_data,
  output logic                  x_last,
  output logic                  range_error,
  output logic [0:0]            state
);

  localparam int CW = (BLOCK_SIZE_LOG > 0) ? BLOCK_SIZE_LOG : 1;
  localparam int SW = DATA_WIDTH + 2;

  localparam logic [0:0] FIRST = 1'b0;
  localparam logic [0:0] REST  = 1'b1;

  // Handshakes: a beat moves on a port when its valid and ready are both high at the
  // rising edge; valid never waits for ready, and a pending output is held until taken.

  logic [DATA_WIDTH-1:0] prev;
  logic [DATA_WIDTH-1:0] pred;
  logic [DATA_WIDTH-1:0] x_next;
  logic [CW-1:0]         count;
  logic signed [SW-1:0]  sum;
  logic                  accept;
  logic                  under;
  logic                  over;
  logic                  last_next;

  assign residual_ready = !x_valid || x_ready;
  assign accept         = residual_valid && residual_ready;

  always_comb begin
    pred = '0;
    if (state == REST) pred = prev;
    sum   = $signed({residual_data[DATA_WIDTH], residual_data}) + $signed({2'b00, pred});
    // Sum spans [-2^DW, 2^(DW+1)-2], so the top two bits tell under- from overflow.
    under = sum[SW-1];
    over  = !sum[SW-1] && sum[SW-2];
    if (under)     x_next = '0;
    else if (over) x_next = '1;
    else           x_next = sum[DATA_WIDTH-1:0];
    if (BLOCK_SIZE_LOG == 0) last_next = 1'b1;
    else                     last_next = (state == REST) && (count == {CW{1'b1}});
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_valid     <= 1'b0;
      x_data      <= '0;
      x_last      <= 1'b0;
      range_error <= 1'b0;
      prev        <= '0;
      count       <= '0;
      state       <= FIRST;
    end else begin
      if (accept) begin
        x_valid <= 1'b1;
        x_data  <= x_next;
        x_last  <= last_next;
        prev    <= x_next;
        if (under || over) range_error <= 1'b1;
        if (BLOCK_SIZE_LOG == 0) begin
          state <= FIRST;
          count <= '0;
        end else if (state == FIRST) begin
          count <= CW'(1);
          state <= REST;
        end else begin
          count <= count + 1'b1;
          if (last_next) state <= FIRST;
        end
      end else if (x_ready) begin
        x_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_firstband_reconstructor.sv
// Directed bench for firstband_reconstructor: a block-of-4 instance for table vectors and
// corner sequences, and a block-of-256 instance fed by a software predictor for round trips.
module tb_firstband_reconstructor;

  logic        clk = 1'b0;
  logic        rst;
  logic        residual_valid;
  logic        residual_ready;
  logic [16:0] residual_data;
  logic        x_valid;
  logic        x_ready;
  logic [15:0] x_data;
  logic        x_last;
  logic        range_error;
  logic [0:0]  state;

  logic        b_residual_valid;
  logic        b_residual_ready;
  logic [16:0] b_residual_data;
  logic        b_x_valid;
  logic        b_x_ready;
  logic [15:0] b_x_data;
  logic        b_x_last;
  logic        b_range_error;
  logic [0:0]  b_state;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [16:0] res;
    logic [15:0] x;
    logic        last;
    logic        err;
  } vec_t;

  vec_t        vecs[12];
  logic [16:0] exp_q[$];
  logic [16:0] res_a[512];

  // Clock and reset
  always #5 clk = ~clk;

  firstband_reconstructor #(.DATA_WIDTH(16), .BLOCK_SIZE_LOG(2)) u_dut (
    .clk(clk), .rst(rst),
    .residual_valid(residual_valid), .residual_ready(residual_ready), .residual_data(residual_data),
    .x_valid(x_valid), .x_ready(x_ready), .x_data(x_data), .x_last(x_last),
    .range_error(range_error), .state(state)
  );

  firstband_reconstructor #(.DATA_WIDTH(16), .BLOCK_SIZE_LOG(8)) u_big (
    .clk(clk), .rst(rst),
    .residual_valid(b_residual_valid), .residual_ready(b_residual_ready), .residual_data(b_residual_data),
    .x_valid(b_x_valid), .x_ready(b_x_ready), .x_data(b_x_data), .x_last(b_x_last),
    .range_error(b_range_error), .state(b_state)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    residual_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Driver: one residual beat accepted at the next edge, outputs checked just after it.
  task automatic send(input logic [16:0] res);
    residual_valid = 1'b1;
    residual_data  = res;
    @(posedge clk);
    #1;
    residual_valid = 1'b0;
  endtask

  task automatic send_check(input string name, input logic [16:0] res, input logic [15:0] x,
                            input logic last, input logic err);
    send(res);
    check({name, " valid"}, 32'(x_valid), 32'd1);
    check({name, " x"}, 32'(x_data), 32'(x));
    check({name, " last"}, 32'(x_last), 32'(last));
    check({name, " err"}, 32'(range_error), 32'(err));
  endtask

  initial begin
    int idx;
    int prev_src;
    int src;
    int pred;
    logic [16:0] stall_data[4];
    logic [16:0] e;

    vecs[0]  = '{17'd5,      16'd5,     1'b0, 1'b0};
    vecs[1]  = '{17'd1,      16'd6,     1'b0, 1'b0};
    vecs[2]  = '{-17'sd2,    16'd4,     1'b0, 1'b0};
    vecs[3]  = '{17'd3,      16'd7,     1'b1, 1'b0};
    vecs[4]  = '{17'd10,     16'd10,    1'b0, 1'b0};
    vecs[5]  = '{-17'sd10,   16'd0,     1'b0, 1'b0};
    vecs[6]  = '{17'd0,      16'd0,     1'b0, 1'b0};
    vecs[7]  = '{17'd65535,  16'd65535, 1'b1, 1'b0};
    vecs[8]  = '{-17'sd1,    16'd0,     1'b0, 1'b1};
    vecs[9]  = '{17'd2,      16'd2,     1'b0, 1'b1};
    vecs[10] = '{17'd0,      16'd2,     1'b0, 1'b1};
    vecs[11] = '{-17'sd2,    16'd0,     1'b1, 1'b1};

    residual_valid   = 1'b0;
    residual_data    = '0;
    x_ready          = 1'b1;
    b_residual_valid = 1'b0;
    b_residual_data  = '0;
    b_x_ready        = 1'b1;

    do_reset();
    check("reset x_valid", 32'(x_valid), 32'd0);
    check("reset x_data", 32'(x_data), 32'd0);
    check("reset x_last", 32'(x_last), 32'd0);
    check("reset range_error", 32'(range_error), 32'd0);
    check("reset state", 32'(state), 32'd0);
    check("reset residual_ready", 32'(residual_ready), 32'd1);

    // Blocks of 4 with full-speed drain, including a low clamp at a block start.
    for (int i = 0; i < 12; i++)
      send_check($sformatf("vec%0d", i), vecs[i].res, vecs[i].x, vecs[i].last, vecs[i].err);

    // Downstream stalled for 10 cycles while the source keeps offering beats.
    @(posedge clk);
    @(posedge clk);
    stall_data = '{17'd1, 17'd1, 17'd1, 17'd1};
    exp_q = '{{1'b0, 16'd1}, {1'b0, 16'd2}, {1'b0, 16'd3}, {1'b1, 16'd4}};
    idx = 0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      @(negedge clk);
      x_ready        = (cyc <= 10) ? 1'b0 : 1'b1;
      residual_valid = (idx < 4);
      residual_data  = stall_data[idx < 4 ? idx : 3];
      #1;
      if (cyc >= 2 && cyc <= 10) begin
        check($sformatf("stall ready c%0d", cyc), 32'(residual_ready), 32'd0);
        check($sformatf("stall hold c%0d", cyc), 32'(x_data), 32'd1);
      end
      if (x_valid && x_ready) begin
        if (exp_q.size() == 0) check("stall extra output", 32'(x_data), 32'hFFFF_FFFF);
        else check("stall out", {15'd0, x_last, x_data}, 32'(exp_q.pop_front()));
      end
      if (residual_valid && residual_ready) idx++;
    end
    residual_valid = 1'b0;
    x_ready = 1'b1;
    check("stall accepted", 32'(idx), 32'd4);
    check("stall drained", 32'(exp_q.size()), 32'd0);
    check("stall x_valid clears", 32'(x_valid), 32'd0);
    @(posedge clk);
    #1;

    // Reset in mid-block restarts the chain; then clamp high in the next block.
    send_check("pre_rst0", 17'd3, 16'd3, 1'b0, 1'b1);
    send_check("pre_rst1", 17'd4, 16'd7, 1'b0, 1'b1);
    do_reset();
    check("mid rst x_valid", 32'(x_valid), 32'd0);
    check("mid rst x_data", 32'(x_data), 32'd0);
    check("mid rst x_last", 32'(x_last), 32'd0);
    check("mid rst range_error", 32'(range_error), 32'd0);
    send_check("post_rst0", 17'd9, 16'd9, 1'b0, 1'b0);
    send_check("post_rst1", 17'd0, 16'd9, 1'b0, 1'b0);
    send_check("post_rst2", 17'd0, 16'd9, 1'b0, 1'b0);
    send_check("post_rst3", 17'd1, 16'd10, 1'b1, 1'b0);
    send_check("hi0", 17'd65535, 16'd65535, 1'b0, 1'b0);
    send_check("hi1", 17'd1, 16'd65535, 1'b0, 1'b1);
    send_check("hi2", -17'sd65535, 16'd0, 1'b0, 1'b1);

    // Round trip through a software predictor with 256-sample blocks and random flow.
    prev_src = 0;
    exp_q.delete();
    for (int i = 0; i < 512; i++) begin
      src = int'($urandom_range(0, 65535));
      pred = (i % 256 == 0) ? 0 : prev_src;
      e = 17'(src - pred);
      res_a[i] = e;
      exp_q.push_back({(i % 256 == 255) ? 1'b1 : 1'b0, 16'(src)});
      prev_src = src;
    end
    idx = 0;
    for (int cyc = 0; cyc < 5000 && (idx < 512 || exp_q.size() != 0); cyc++) begin
      @(negedge clk);
      b_residual_valid = (idx < 512) && ($urandom_range(0, 3) != 0);
      b_residual_data  = res_a[idx < 512 ? idx : 511];
      b_x_ready        = ($urandom_range(0, 3) != 0);
      #1;
      if (b_x_valid && b_x_ready) begin
        if (exp_q.size() == 0) check("loop extra output", 32'(b_x_data), 32'hFFFF_FFFF);
        else check("loop out", {15'd0, b_x_last, b_x_data}, 32'(exp_q.pop_front()));
      end
      if (b_residual_valid && b_residual_ready) idx++;
    end
    b_residual_valid = 1'b0;
    check("loop all sent", 32'(idx), 32'd512);
    check("loop all received", 32'(exp_q.size()), 32'd0);
    check("loop range_error", 32'(b_range_error), 32'd0);
    check("loop end state", 32'(b_state), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
